// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU load/store path (port 0) and a
// debug/DMA requester (port 1). Accesses are serialised; per-port saturating grant counters.
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int FIXED_PRI = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);

  // state     | meaning
  // ST_IDLE   | no access in flight; arbitrate and latch the winning request
  // ST_ACCESS | single memory cycle, exactly one of mem_we / mem_re asserted
  // ST_RESP   | one-cycle ack to the winner, grant counter and pointer update
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                grant;
  logic                last_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt0_q, cnt1_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant   = 1'b1;
          state_d = ST_ACCESS;
          if (req0 && !req1)
            win_d = 1'b0;
          else if (req1 && !req0)
            win_d = 1'b1;
          else if (FIXED_PRI != 0)
            win_d = 1'b0;
          else
            win_d = ~last_q;  // contention: the port not served last wins
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobes and acks are gated by reset so an aborted access never reaches memory.
  assign mem_we    = (state_q == ST_ACCESS) && we_q && !reset;
  assign mem_re    = (state_q == ST_ACCESS) && !we_q && !reset;
  assign ack0      = (state_q == ST_RESP) && !win_q && !reset;
  assign ack1      = (state_q == ST_RESP) && win_q && !reset;
  assign busy      = (state_q != ST_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign gnt_cnt0  = cnt0_q;
  assign gnt_cnt1  = cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        win_q <= win_d;
        if (win_d) begin
          we_q    <= we1;
          addr_q  <= addr1;
          wdata_q <= wdata1;
        end else begin
          we_q    <= we0;
          addr_q  <= addr0;
          wdata_q <= wdata0;
        end
      end
      if (state_q == ST_ACCESS && !we_q)
        rdata_q <= mem_rdata;
      if (state_q == ST_RESP) begin
        last_q <= win_q;
        if (win_q) begin
          if (cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + CNT_ONE;
        end else begin
          if (cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + CNT_ONE;
        end
      end
    end
  end

endmodule
